// File: rtl/mips_trace_unit.sv
// mips_trace_unit: triggered capture of core debug status into a FIFO,
// streamed out as two 32-bit words per record over valid/ready.
module mips_trace_unit #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_arm,
    input  logic        i_trig_any,
    input  logic [15:0] i_trig_pc,
    input  logic [7:0]  i_max_rec,
    input  logic [15:0] i_pc_addr,
    input  logic [5:0]  i_i_code,
    input  logic [31:0] i_o_alu,
    input  logic        i_zero,
    output logic [31:0] o_tr_data,
    output logic        o_tr_valid,
    input  logic        i_tr_ready,
    output logic        o_tr_last,
    output logic        o_busy,
    output logic [1:0]  o_state,
    output logic [7:0]  o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
    state_t r_state, w_next;
    logic        r_trig_any;
    logic [15:0] r_trig_pc;
    logic [7:0]  r_max_rec, r_rec_cnt, r_drop_cnt;
    logic [63:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_word;
    logic        w_empty, w_full, w_hs, w_pop, w_hit, w_sample, w_push, w_arm, w_last_smp;
    logic [7:0]  w_cnt_nxt;
    logic [63:0] w_head;
    assign w_empty    = r_wr_ptr == r_rd_ptr;
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_hs       = !w_empty && i_tr_ready;
    assign w_pop      = w_hs && r_word;
    assign w_hit      = r_trig_any || (i_pc_addr == r_trig_pc);
    assign w_sample   = (r_state == ARMED && w_hit) || r_state == CAPTURE;
    // a completing pop frees the head slot, so a full FIFO may still accept this sample
    assign w_push     = w_sample && (!w_full || w_pop);
    assign w_arm      = r_state == IDLE && i_arm;
    assign w_cnt_nxt  = r_rec_cnt + {7'd0, r_rec_cnt != 8'hFF};
    assign w_last_smp = r_max_rec != 8'd0 && w_cnt_nxt == r_max_rec;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_arm ? ARMED : IDLE;
            ARMED:   w_next = w_hit ? (w_last_smp ? DONE : CAPTURE) : ARMED;
            CAPTURE: w_next = w_last_smp ? DONE : CAPTURE;
            DONE:    w_next = (w_empty && !r_word) ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_any <= 1'b0;
            r_trig_pc  <= 16'd0;
            r_max_rec  <= 8'd0;
            r_rec_cnt  <= 8'd0;
            r_drop_cnt <= 8'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_word     <= 1'b0;
        end else begin
            if (w_arm) begin
                r_trig_any <= i_trig_any;
                r_trig_pc  <= i_trig_pc;
                r_max_rec  <= i_max_rec;
                r_rec_cnt  <= 8'd0;
                r_drop_cnt <= 8'd0;
            end else if (w_sample) begin
                r_rec_cnt <= w_cnt_nxt;
                if (!w_push && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_hs)   r_word   <= !r_word;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {i_pc_addr, 4'b0, i_i_code, 5'b0, i_zero, i_o_alu};
    end
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign o_tr_valid = !w_empty;
    assign o_tr_last  = !w_empty && r_word;
    assign o_tr_data  = w_empty ? 32'd0 : (r_word ? w_head[31:0] : w_head[63:32]);
    assign o_busy     = r_state != IDLE;
    assign o_state    = r_state;
    assign o_drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_mips_trace_unit.sv
// tb_mips_trace_unit: directed scenarios with a scoreboard queue of expected
// trace words, compared whenever the DUT presents a valid word.
module tb_mips_trace_unit;
    logic        clk = 0, rst_n = 0, arm = 0, trig_any = 0, z = 0, ready = 0;
    logic [15:0] trig_pc = 0, pc = 0;
    logic [7:0]  max_rec = 0;
    logic [5:0]  code = 0;
    logic [31:0] alu = 0;
    logic [31:0] tr_data;
    logic        tr_valid, tr_last, busy;
    logic [1:0]  state;
    logic [7:0]  drop_cnt;
    typedef struct packed {logic [31:0] d; logic l;} exp_t;
    exp_t q[$];
    int checks = 0, failures = 0, hs = 0, hs0 = 0;

    mips_trace_unit #(.DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_arm(arm), .i_trig_any(trig_any), .i_trig_pc(trig_pc),
        .i_max_rec(max_rec), .i_pc_addr(pc), .i_i_code(code), .i_o_alu(alu), .i_zero(z),
        .o_tr_data(tr_data), .o_tr_valid(tr_valid), .i_tr_ready(ready), .o_tr_last(tr_last),
        .o_busy(busy), .o_state(state), .o_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // compare the presented word against the scoreboard head, then cross one edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst_n && tr_valid) begin
            if (q.size() == 0) chk("sb_nonempty", 32'(q.size()), 32'd1);
            else begin
                e = q[0];
                chk("tr_data", tr_data, e.d);
                chk("tr_last", {31'd0, tr_last}, {31'd0, e.l});
                if (ready) begin
                    void'(q.pop_front());
                    hs++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [15:0] p, input logic [5:0] c, input logic [31:0] a,
                       input logic zz, input bit store);
        pc = p; code = c; alu = a; z = zz;
        if (store) begin
            q.push_back(exp_t'{d: {p, 4'b0, c, 5'b0, zz}, l: 1'b0});
            q.push_back(exp_t'{d: a, l: 1'b1});
        end
        tick();
    endtask

    task automatic do_arm(input logic any, input logic [15:0] tpc, input logic [7:0] mr);
        trig_any = any; trig_pc = tpc; max_rec = mr; arm = 1;
        tick();
        arm = 0;
        chk("armed", 32'(state), 32'd1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // reset
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(tr_valid), 0);
        chk("rst_last", 32'(tr_last), 0);
        chk("rst_data", tr_data, 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        rst_n = 1;
        // single record
        do_arm(1, 16'h0, 8'd1);
        cyc(16'h0004, 6'h08, 32'h0000_0014, 0, 1);
        chk("t1_done", 32'(state), 3);
        chk("t1_valid", 32'(tr_valid), 1);
        chk("t1_w0", tr_data, 32'h0004_0200);
        chk("t1_last0", 32'(tr_last), 0);
        ready = 1;
        tick();
        chk("t1_last1", 32'(tr_last), 1);
        chk("t1_w1", tr_data, 32'h0000_0014);
        tick();
        chk("t1_still_done", 32'(state), 3);
        tick();
        chk("t1_idle", 32'(state), 0);
        chk("t1_sb_empty", 32'(q.size()), 0);
        // PC trigger, 3 records
        hs0 = hs;
        pc = 0;
        do_arm(0, 16'h000C, 8'd3);
        for (int i = 0; i < 8; i++)
            cyc(16'(4 * i), 6'(6'h20 + i), 32'h1000 + i, 1'(i & 1), (4 * i >= 12) && (4 * i <= 20));
        drain(12);
        chk("t2_hs", 32'(hs - hs0), 6);
        chk("t2_drop", 32'(drop_cnt), 0);
        chk("t2_sb_empty", 32'(q.size()), 0);
        chk("t2_idle", 32'(state), 0);
        // overflow: 12 samples into 8 slots
        ready = 0;
        do_arm(1, 16'h0, 8'd12);
        for (int i = 0; i < 12; i++)
            cyc(16'(16'h100 + 4 * i), 6'(6'h3F - i), $urandom, 1'(i & 1), i < 8);
        chk("t3_done", 32'(state), 3);
        chk("t3_drop", 32'(drop_cnt), 4);
        chk("t3_valid", 32'(tr_valid), 1);
        ready = 1;
        drain(20);
        chk("t3_sb_empty", 32'(q.size()), 0);
        chk("t3_idle", 32'(state), 0);
        // random backpressure, 5 records
        hs0 = hs;
        do_arm(1, 16'h0, 8'd5);
        for (int i = 0; i < 5; i++) begin
            ready = 1'($urandom_range(0, 1));
            cyc(16'(16'h400 + 4 * i), 6'(i), $urandom, 1'(i & 1), 1);
        end
        for (int i = 0; i < 40; i++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
        end
        ready = 1;
        drain(12);
        chk("t4_hs", 32'(hs - hs0), 10);
        chk("t4_sb_empty", 32'(q.size()), 0);
        chk("t4_idle", 32'(state), 0);
        chk("t4_drop", 32'(drop_cnt), 0);
        // full FIFO with simultaneous word1 pop and push
        ready = 0;
        do_arm(1, 16'h0, 8'd9);
        for (int i = 0; i < 9; i++) begin
            ready = (i >= 7);
            cyc(16'(16'h200 + 4 * i), 6'(6'h10 + i), $urandom, 1'(i & 1), 1);
        end
        chk("t5_drop", 32'(drop_cnt), 0);
        chk("t5_done", 32'(state), 3);
        ready = 1;
        drain(24);
        chk("t5_sb_empty", 32'(q.size()), 0);
        chk("t5_idle", 32'(state), 0);
        // reset mid-capture
        ready = 0;
        do_arm(1, 16'h0, 8'd0);
        for (int i = 0; i < 3; i++) cyc(16'(16'h300 + 4 * i), 6'(i), $urandom, 0, 1);
        chk("t6_capture", 32'(state), 2);
        chk("t6_valid_pre", 32'(tr_valid), 1);
        rst_n = 0;
        #1;
        chk("t6_valid_rst", 32'(tr_valid), 0);
        chk("t6_state_rst", 32'(state), 0);
        chk("t6_busy_rst", 32'(busy), 0);
        chk("t6_last_rst", 32'(tr_last), 0);
        q.delete();
        tick();
        rst_n = 1;
        ready = 1;
        do_arm(1, 16'h0, 8'd2);
        cyc(16'h0500, 6'h2A, 32'hDEAD_BEEF, 1, 1);
        cyc(16'h0504, 6'h15, 32'h1234_5678, 0, 1);
        drain(8);
        chk("t6_sb_empty", 32'(q.size()), 0);
        chk("t6_idle", 32'(state), 0);
        chk("t6_drop", 32'(drop_cnt), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
